// File: rtl/spi_command_deserializer_if.sv
// Register-bank side of the SPI command deserializer: decoded op-code and
// operand bytes flow out to the bank, and the bank's response byte flows back.
interface spi_command_deserializer_if;
    logic [7:0]  op_code_out;
    logic        op_code_valid_out;
    logic [7:0]  operand_out;
    logic        operand_valid_out;
    logic [31:0] operand_count_out;
    logic [7:0]  response_in;
    logic        response_valid_in;

    modport master (
        output op_code_out,
        output op_code_valid_out,
        output operand_out,
        output operand_valid_out,
        output operand_count_out,
        input  response_in,
        input  response_valid_in
    );

    modport slave (
        input  op_code_out,
        input  op_code_valid_out,
        input  operand_out,
        input  operand_valid_out,
        input  operand_count_out,
        output response_in,
        output response_valid_in
    );
endinterface

// File: rtl/spi_command_deserializer.sv
// SPI mode-0 peripheral front-end. The SPI pins are oversampled on clock_in.
// The first byte of each select-low window becomes the op-code. Every later
// byte is an operand, and the register-bank response is shifted out on CIPO.
module spi_command_deserializer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock_in,
    input  logic reset_in,
    input  logic spi_clock_in,
    input  logic spi_select_in,
    input  logic spi_data_in,
    output logic spi_data_out,
    output logic spi_data_out_enable,
    spi_command_deserializer_if.master bank
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] OP_CODE = 2'd1;
    localparam logic [1:0] OPERAND = 2'd2;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] select_sync;
    logic [SYNC_STAGES-1:0] data_sync;

    logic       sclk_prev;
    logic       select_prev;
    logic [1:0] state;
    logic [2:0] bit_count;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;
    logic       byte_done;

    logic       sclk_now;
    logic       select_now;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       select_fall;
    logic       select_rise;
    logic [7:0] rx_next;

    // Pin synchronizers run free, even through reset, so edge history is settled on release
    always_ff @(posedge clock_in) begin
        sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], spi_clock_in};
        select_sync <= {select_sync[SYNC_STAGES-2:0], spi_select_in};
        data_sync   <= {data_sync[SYNC_STAGES-2:0], spi_data_in};
    end

    assign sclk_now    = sclk_sync[SYNC_STAGES-1];
    assign select_now  = select_sync[SYNC_STAGES-1];
    assign sclk_rise   = sclk_now & ~sclk_prev;
    assign sclk_fall   = ~sclk_now & sclk_prev;
    assign select_fall = ~select_now & select_prev;
    assign select_rise = select_now & ~select_prev;
    assign rx_next     = {rx_shift[6:0], data_sync[SYNC_STAGES-1]};

    assign spi_data_out        = tx_shift[7];
    assign spi_data_out_enable = (state != IDLE);

    // Edge-detector history; clearing select_prev to 0 hides a select already low at release
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            sclk_prev   <= 1'b0;
            select_prev <= 1'b0;
        end else begin
            sclk_prev   <= sclk_now;
            select_prev <= select_now;
        end
    end

    // Transaction FSM: byte assembly, op-code/operand hand-off and CIPO shifting
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state                  <= IDLE;
            bit_count              <= 3'd0;
            rx_shift               <= 8'h00;
            tx_shift               <= 8'h00;
            byte_done              <= 1'b0;
            bank.op_code_out       <= 8'h00;
            bank.op_code_valid_out <= 1'b0;
            bank.operand_out       <= 8'h00;
            bank.operand_valid_out <= 1'b0;
            bank.operand_count_out <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (select_fall) begin
                        state     <= OP_CODE;
                        bit_count <= 3'd0;
                        byte_done <= 1'b0;
                        tx_shift  <= 8'h00;
                    end
                end
                OP_CODE, OPERAND: begin
                    if (select_rise) begin
                        state                  <= IDLE;
                        bit_count              <= 3'd0;
                        tx_shift               <= 8'h00;
                        byte_done              <= 1'b0;
                        bank.op_code_valid_out <= 1'b0;
                        bank.operand_valid_out <= 1'b0;
                        bank.operand_count_out <= 32'd0;
                    end else begin
                        if (sclk_rise) begin
                            rx_shift               <= rx_next;
                            bit_count              <= bit_count + 3'd1;
                            bank.operand_valid_out <= 1'b0;
                            if (bit_count == 3'd7) begin
                                byte_done <= 1'b1;
                                if (state == OP_CODE) begin
                                    bank.op_code_out       <= rx_next;
                                    bank.op_code_valid_out <= 1'b1;
                                    bank.operand_count_out <= 32'd0;
                                    state                  <= OPERAND;
                                end else begin
                                    bank.operand_out       <= rx_next;
                                    bank.operand_valid_out <= 1'b1;
                                    if (bank.operand_count_out != 32'hFFFF_FFFF) begin
                                        bank.operand_count_out <= bank.operand_count_out + 32'd1;
                                    end
                                end
                            end
                        end
                        if (sclk_fall) begin
                            if (byte_done && state == OPERAND) begin
                                tx_shift  <= bank.response_valid_in ? bank.response_in : 8'h00;
                                byte_done <= 1'b0;
                            end else begin
                                tx_shift <= {tx_shift[6:0], 1'b0};
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
